ff_capture_fifo: RTL and testbench

Capture buffer directly downstream of the registered valid/data flip-flop stage. It absorbs that stage's `valid_o`/`data_o` stream, which has no backpressure, into a first-word-fall-through FIFO. It presents the stored data to the consumer through a ready/valid handshake. Words that arrive when no slot is free are dropped and counted, never stalled, because the upstream stage cannot be held.

---
 rtl/ff_capture_fifo.sv | 85 ++++++++
 tb/tb_ff_capture_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_capture_fifo.sv
// ff_capture_fifo: first-word-fall-through capture FIFO that sits behind a
// registered valid/data stage with no backpressure. Words that arrive while
// the FIFO is full (and not being popped) are dropped and counted.
module ff_capture_fifo #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic [SIZE-1:0]            data_i,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [SIZE-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            pop;
  logic            push;
  logic            drop;

  // Drop counter sticks at all-ones rather than wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Status is derived purely from the registered pointers; the extra MSB
  // distinguishes full from empty when the address bits match.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count    = wptr - rptr;
  assign rd_valid = ~empty;
  assign rd_data  = mem[rptr[AW-1:0]];

  // A full FIFO still accepts a word when the head leaves in the same cycle;
  // this is the only combinational path (rd_ready -> push).
  assign pop  = rd_valid & rd_ready;
  assign push = valid_i & (~full | pop);
  assign drop = valid_i & full & ~pop;

  // Storage array: written on push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= data_i;
    end
  end

  // Read and write pointers advance on pop and push respectively.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Overflow bookkeeping: a drop in the same cycle as a clear wins and
  // restarts the count at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(drop_cnt);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end
  end

endmodule

// File: tb/tb_ff_capture_fifo.sv
// Self-checking bench for ff_capture_fifo: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_ff_capture_fifo;

  localparam int SIZE  = 32;
  localparam int DEPTH = 8;

  logic                    clk;
  logic                    reset;
  logic                    valid_i;
  logic [SIZE-1:0]         data_i;
  logic                    rd_ready;
  logic                    clr_ovf;
  logic                    rd_valid;
  logic [SIZE-1:0]         rd_data;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic [15:0]             drop_cnt;

  ff_capture_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .rd_ready (rd_ready),
    .clr_ovf  (clr_ovf),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [SIZE-1:0] q[$];
  bit              m_ovf;
  int              m_dcnt;
  logic [SIZE-1:0] last_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle: inputs applied just after a rising edge, outputs checked
  // on the falling edge, model advanced, then wait for the next rising edge.
  task automatic step(input logic v, input logic [SIZE-1:0] d, input logic rdy,
                      input logic clr, input bit chk);
    bit pop_m, full_m, drop_m;
    valid_i  = v;
    data_i   = d;
    rd_ready = rdy;
    clr_ovf  = clr;
    @(negedge clk);
    if (chk) begin
      check_eq("rd_valid", rd_valid, q.size() != 0);
      check_eq("count",    count,    q.size());
      check_eq("full",     full,     q.size() == DEPTH);
      check_eq("empty",    empty,    q.size() == 0);
      check_eq("overflow", overflow, m_ovf);
      check_eq("drop_cnt", drop_cnt, m_dcnt);
      if (q.size() != 0) check_eq("rd_data", rd_data, q[0]);
    end
    pop_m  = (q.size() != 0) && rdy;
    full_m = (q.size() == DEPTH);
    drop_m = v && full_m && !pop_m;
    if (pop_m) last_rd = q.pop_front();
    if (v && !drop_m) q.push_back(d);
    if (drop_m) begin
      m_ovf  = 1'b1;
      m_dcnt = clr ? 1 : ((m_dcnt == 65535) ? 65535 : m_dcnt + 1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_dcnt = 0;
  endtask

  initial begin
    reset    = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    last_rd  = '0;
    model_reset();

    // Power-on reset
    #2;
    check_eq("por_count", count, 0);
    check_eq("por_empty", empty, 1);
    check_eq("por_rd_valid", rd_valid, 0);
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: asynchronous reset mid-stream with five words stored
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b1);
    check_eq("t1_count5", count, 5);
    valid_i = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("t1_rst_count", count, 0);
    check_eq("t1_rst_empty", empty, 1);
    check_eq("t1_rst_rd_valid", rd_valid, 0);
    check_eq("t1_rst_overflow", overflow, 0);
    check_eq("t1_rst_drop_cnt", drop_cnt, 0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
    check_eq("t1_a5_valid", rd_valid, 1);
    check_eq("t1_a5_data", rd_data, 32'hA5A5A5A5);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Test 2: fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0, 1'b1);
    check_eq("t2_full", full, 1);
    check_eq("t2_count8", count, 8);
    step(1'b1, 32'h9, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    check_eq("t2_overflow", overflow, 1);
    check_eq("t2_drop_cnt", drop_cnt, 2);
    for (int i = 1; i <= 8; i++) begin
      check_eq("t2_drain", rd_data, i);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    end
    check_eq("t2_empty", empty, 1);

    // Test 3: push and pop together while full
    for (int i = 0; i < 8; i++) step(1'b1, 32'h30 + i, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
    check_eq("t3_count", count, 8);
    check_eq("t3_drop_cnt", drop_cnt, 2);
    check_eq("t3_head", rd_data, 32'h31);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t3_last", last_rd, 32'h55);
    check_eq("t3_empty", empty, 1);

    // Test 4: wrap-around streaming
    for (int i = 0; i < 24; i++) begin
      step(1'b1, i, 1'b1, 1'b0, 1'b1);
      check_eq("t4_count_le1", count <= 1, 1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_eq("t4_last", last_rd, 23);
    check_eq("t4_drop_cnt", drop_cnt, 2);

    // Test 5: clear versus drop
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t5_clr_dcnt", drop_cnt, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h50 + i, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    check_eq("t5_dcnt3", drop_cnt, 3);
    step(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1);
    check_eq("t5_both_ovf", overflow, 1);
    check_eq("t5_both_dcnt", drop_cnt, 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t5_clr_ovf", overflow, 0);
    check_eq("t5_clr_dcnt2", drop_cnt, 0);

    // Test 6: drop counter saturation (FIFO still full)
    for (int i = 0; i < 65540; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
    check_eq("t6_sat", drop_cnt, 16'hFFFF);
    step(1'b1, '0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_no_wrap", drop_cnt, 16'hFFFF);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Random phase against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 40) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
